// File: rtl/mem_bhw_port.sv
// mem_bhw_port
// Single-port data memory with a valid/ready request/response interface.
// Supports byte, halfword, word and (when DATA_W=64) doubleword access with
// big-endian lane mapping: byte offset 0 lives in bits [DATA_W-1:DATA_W-8].
// Misaligned or oversized requests return rsp_err=1 and never touch memory.
//
// Parameters:
//   DATA_W  memory word width in bits, 32 or 64
//   ADDR_W  byte-address width; depth = 2^ADDR_W / (DATA_W/8) words
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   req_valid / req_ready   request handshake (req_ready is combinational
//                           from rsp_ready)
//   req_we, req_size        store/load select, log2 of access size in bytes
//   req_addr, req_wdata     byte address, right-justified store data
//   req_signed              sign-extend load result
//   rsp_valid / rsp_ready   response handshake, one response per request
//   rsp_rdata, rsp_err      right-justified load data, error flag
//
// Optional feature macro:
//   MEM_SIGNED_LOAD_EN      when defined, loads with req_signed=1 are
//                           sign-extended; otherwise all loads zero-extend.

module mem_bhw_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         BYTES   = DATA_W / 8;
    localparam int         OFF_W   = $clog2(BYTES);
    localparam int         IDX_W   = ADDR_W - OFF_W;
    localparam int         DEPTH   = 1 << IDX_W;
    localparam logic [3:0] BYTES_L = 4'(BYTES);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Byte mask covering the low nbytes bytes of a word (right-justified).
    function automatic logic [DATA_W-1:0] size_mask(input logic [3:0] nbytes);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (4'(k) < nbytes) begin
                m[8*k +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_q;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic              load_q, load_d;
    logic [1:0]        size_q, size_d;
    logic [OFF_W-1:0]  off_q, off_d;

    logic              accept;
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        req_nbytes;
    logic [3:0]        req_shift;
    logic              req_err;
    logic [BYTES-1:0]  lane_en;
    logic [DATA_W-1:0] wdata_aligned;

    logic [3:0]        rsp_nbytes;
    logic [3:0]        rsp_shift;
    logic [DATA_W-1:0] rsp_mask;
    logic [DATA_W-1:0] rsp_ext;

    assign rsp_valid = (state_q == FULL);
    assign req_ready = rst_n & (~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

    // Request decode. req_shift is the number of bytes between the last
    // accessed lane and the word LSB; it is only meaningful for legal
    // requests and places the right-justified value into its big-endian lanes.
    always_comb begin
        req_off       = req_addr[OFF_W-1:0];
        req_idx       = req_addr[ADDR_W-1:OFF_W];
        req_nbytes    = 4'd1 << req_size;
        req_err       = (req_nbytes > BYTES_L) ||
                        ((req_off & OFF_W'(req_nbytes - 4'd1)) != '0);
        req_shift     = BYTES_L - 4'(req_off) - req_nbytes;
        wdata_aligned = (req_wdata & size_mask(req_nbytes)) << {req_shift, 3'b000};
        lane_en       = '0;
        for (int k = 0; k < BYTES; k++) begin
            lane_en[k] = (4'(k) >= 4'(req_off)) &&
                         (4'(k) < (4'(req_off) + req_nbytes));
        end
    end

    // Block RAM: per-lane writes and a synchronous read, both on the
    // accepting edge. Neither the array nor its read register is reset, and
    // rsp_rdata is gated so stale read data never reaches the output.
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_we) begin
                for (int k = 0; k < BYTES; k++) begin
                    if (lane_en[k]) begin
                        mem[req_idx][DATA_W-1-8*k -: 8] <= wdata_aligned[DATA_W-1-8*k -: 8];
                    end
                end
            end else begin
                rd_word_q <= mem[req_idx];
            end
        end
    end

`ifdef MEM_SIGNED_LOAD_EN
    logic signed_q, signed_d;
`else
    logic unused_req_signed;
    assign unused_req_signed = req_signed;
`endif

    // Response slot control. A new accept always overwrites the slot (it can
    // only happen when the slot is empty or being drained this same edge).
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        load_d   = load_q;
        size_d   = size_q;
        off_d    = off_q;
`ifdef MEM_SIGNED_LOAD_EN
        signed_d = signed_q;
`endif
        if (accept) begin
            state_d  = FULL;
            err_d    = req_err;
            load_d   = ~req_we & ~req_err;
            size_d   = req_size;
            off_d    = req_off;
`ifdef MEM_SIGNED_LOAD_EN
            signed_d = req_signed;
`endif
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= '0;
`ifdef MEM_SIGNED_LOAD_EN
            signed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            load_q   <= load_d;
            size_q   <= size_d;
            off_q    <= off_d;
`ifdef MEM_SIGNED_LOAD_EN
            signed_q <= signed_d;
`endif
        end
    end

    // Extract the loaded value from the registered word and right-justify it.
    always_comb begin
        rsp_nbytes = 4'd1 << size_q;
        rsp_shift  = BYTES_L - 4'(off_q) - rsp_nbytes;
        rsp_mask   = size_mask(rsp_nbytes);
        rsp_ext    = (rd_word_q >> {rsp_shift, 3'b000}) & rsp_mask;
`ifdef MEM_SIGNED_LOAD_EN
        // Full-word loads have an all-ones mask, so filling is a no-op there.
        if (signed_q) begin
            case (size_q)
                2'd0:    rsp_ext = rsp_ext | (~rsp_mask & {DATA_W{rsp_ext[7]}});
                2'd1:    rsp_ext = rsp_ext | (~rsp_mask & {DATA_W{rsp_ext[15]}});
                2'd2:    rsp_ext = rsp_ext | (~rsp_mask & {DATA_W{rsp_ext[31]}});
                default: rsp_ext = rsp_ext | (~rsp_mask & {DATA_W{rsp_ext[DATA_W-1]}});
            endcase
        end
`endif
    end

    assign rsp_rdata = (rsp_valid && load_q) ? rsp_ext : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_mem_bhw_port.sv
// tb_mem_bhw_port
// Directed bench for mem_bhw_port with default parameters (DATA_W=32,
// ADDR_W=14). Expected values for signed loads follow MEM_SIGNED_LOAD_EN.

module tb_mem_bhw_port;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 14;

`ifdef MEM_SIGNED_LOAD_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_signed;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int error_count = 0;
    int check_count = 0;

    typedef struct {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              sgn;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    mem_bhw_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", error_count + 1, check_count + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic we, input logic [1:0] size,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic sgn, input logic exp_err,
                          input logic [DATA_W-1:0] exp_rdata);
        vec_t v;
        v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.sgn = sgn; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        vecs.push_back(v);
    endtask

    // One request with rsp_ready held high; response checked the cycle after.
    task automatic applyStimulus(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_signed = v.sgn;
        rsp_ready  = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("vec%0d_req_ready", idx), {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("vec%0d_rsp_valid", idx), {63'd0, rsp_valid}, 64'd1);
        checkOutput($sformatf("vec%0d_rsp_err", idx), {63'd0, rsp_err}, {63'd0, v.exp_err});
        checkOutput($sformatf("vec%0d_rsp_rdata", idx), {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
    endtask

    initial begin
        logic [DATA_W-1:0] bp_exp [4];
        bp_exp[0] = 32'hCAFE0001;
        bp_exp[1] = 32'hCAFE0002;
        bp_exp[2] = 32'hCAFE0003;
        bp_exp[3] = 32'hCAFE0004;

        //     we    size  addr      wdata         sgn   err   rdata
        addVec(1'b1, 2'd2, 14'h0010, 32'h11223344, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 2'd0, 14'h0011, 32'h0,        1'b0, 1'b0, 32'h00000022);
        addVec(1'b0, 2'd1, 14'h0012, 32'h0,        1'b0, 1'b0, 32'h00003344);
        addVec(1'b1, 2'd0, 14'h0013, 32'h000000AB, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 2'd2, 14'h0010, 32'h0,        1'b0, 1'b0, 32'h112233AB);
        addVec(1'b0, 2'd1, 14'h0011, 32'h0,        1'b0, 1'b1, 32'h0);
        addVec(1'b1, 2'd2, 14'h0012, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0);
        addVec(1'b0, 2'd2, 14'h0010, 32'h0,        1'b0, 1'b0, 32'h112233AB);
        addVec(1'b0, 2'd3, 14'h0010, 32'h0,        1'b0, 1'b1, 32'h0);
        addVec(1'b0, 2'd0, 14'h0010, 32'h0,        1'b0, 1'b0, 32'h00000011);
        addVec(1'b0, 2'd1, 14'h0010, 32'h0,        1'b0, 1'b0, 32'h00001122);
        addVec(1'b1, 2'd2, 14'h0020, 32'h00000000, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 2'd0, 14'h0020, 32'h12345680, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 2'd0, 14'h0020, 32'h0,        1'b1, 1'b0,
               SIGNED_EN ? 32'hFFFFFF80 : 32'h00000080);
        addVec(1'b0, 2'd0, 14'h0020, 32'h0,        1'b0, 1'b0, 32'h00000080);
        addVec(1'b1, 2'd1, 14'h0022, 32'h1234BEEF, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 2'd2, 14'h0020, 32'h0,        1'b0, 1'b0, 32'h8000BEEF);
        addVec(1'b0, 2'd1, 14'h0022, 32'h0,        1'b1, 1'b0,
               SIGNED_EN ? 32'hFFFFBEEF : 32'h0000BEEF);
        addVec(1'b0, 2'd0, 14'h0021, 32'h0,        1'b1, 1'b0, 32'h00000000);
        addVec(1'b0, 2'd2, 14'h0020, 32'h0,        1'b1, 1'b0, 32'h8000BEEF);
        addVec(1'b1, 2'd2, 14'h0040, 32'hCAFE0001, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 2'd2, 14'h0044, 32'hCAFE0002, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 2'd2, 14'h0048, 32'hCAFE0003, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 2'd2, 14'h004C, 32'hCAFE0004, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 2'd2, 14'h0050, 32'h5A5A1234, 1'b0, 1'b0, 32'h0);

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_addr   = '0;
        req_wdata  = '0;
        req_signed = 1'b0;
        rsp_ready  = 1'b1;

        // Reset state, with a request already waiting.
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        #1;
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("reset_rsp_err",   {63'd0, rsp_err},   64'd0);
        checkOutput("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("idle_req_ready", {63'd0, req_ready}, 64'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // Backpressure: first response stalls three extra cycles, then the
        // remaining loads stream at one per cycle.
        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 14'h0040;
        #1;
        checkOutput("bp_ready_empty", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_addr = 14'h0044;
        @(negedge clk);
        checkOutput("bp_first_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("bp_first_rdata", {32'd0, rsp_rdata}, {32'd0, bp_exp[0]});
        checkOutput("bp_first_ready", {63'd0, req_ready}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_valid", c), {63'd0, rsp_valid}, 64'd1);
            checkOutput($sformatf("bp_hold%0d_rdata", c), {32'd0, rsp_rdata}, {32'd0, bp_exp[0]});
            checkOutput($sformatf("bp_hold%0d_ready", c), {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {63'd0, req_ready}, 64'd1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) req_addr = 14'(32'h40 + 4 * (i + 1));
            else       req_valid = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("bp_stream%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
            checkOutput($sformatf("bp_stream%0d_rdata", i), {32'd0, rsp_rdata}, {32'd0, bp_exp[i]});
        end
        @(negedge clk);
        checkOutput("bp_drained_valid", {63'd0, rsp_valid}, 64'd0);

        // Reset while FULL; a store attempted during reset must not commit.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 14'h0050;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_full_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("rst_full_rdata", {32'd0, rsp_rdata}, 64'h5A5A1234);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_async_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("rst_async_rdata", {32'd0, rsp_rdata}, 64'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_wdata = 32'hFFFFFFFF;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_hold_ready", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus('{1'b0, 2'd2, 14'h0050, 32'h0, 1'b0, 1'b0, 32'h5A5A1234}, 100);
        applyStimulus('{1'b0, 2'd2, 14'h0010, 32'h0, 1'b0, 1'b0, 32'h112233AB}, 101);
        applyStimulus('{1'b0, 2'd2, 14'h004C, 32'h0, 1'b0, 1'b0, 32'hCAFE0004}, 102);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/mem_bhw_port.md
# mem_bhw_port

Parametrised single-port data memory with a valid/ready request/response interface. It supports byte, halfword, word and (for 64-bit builds) doubleword access with big-endian lane mapping, and flags misaligned accesses. It sits between the CPU load/store unit (or the I/O polling master) and on-chip block RAM, replacing fixed 32-bit halfword-split memories. It generalises width and depth, adds backpressure, per-lane byte writes and an error response.

## Interface
Parameters:
- DATA_W, 32, memory word width in bits; 32 or 64 only.
- ADDR_W, 14, byte-address width; depth = 2^ADDR_W / (DATA_W/8) words.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  log2(bytes): 0 byte, 1 half, 2 word, 3 double.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store value, right-justified (LSBs).
- req_signed  in  1  sign-extend load result (honoured only with MEM_SIGNED_LOAD_EN).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at rising edge.
- rsp_rdata  out  DATA_W  load result, right-justified; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or oversized.

## Operation
- Word index = req_addr[ADDR_W-1:log2(DATA_W/8)]; offset = low log2(DATA_W/8) bits.
- Big-endian: byte at offset 0 is bits [DATA_W-1:DATA_W-8]; byte k is bits [DATA_W-1-8k -: 8].
- Error when offset not a multiple of 2^req_size, or 2^req_size > DATA_W/8. Error requests do not write memory and produce rsp_err=1, rsp_rdata=0.
- Store: req_wdata[8·2^size-1:0] is shifted into lanes offset..offset+2^size-1; only those byte lanes are written (per-lane enables, no read-modify-write). Commit occurs on the accepting edge.
- Load: RAM is read synchronously on the accepting edge into an internal register. Size, offset and signed flag are captured alongside. rsp_rdata is extracted from the registered data and zero-extended, or sign-extended per Configuration.
- Every accepted request, load or store, produces exactly one response, in order.
- Two-state control: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). EMPTY→FULL on accept. FULL→EMPTY on rsp_ready with no new accept. FULL→FULL on rsp_ready with a simultaneous accept, which loads the new response. While FULL with rsp_ready=0, all response outputs hold.
- req_ready = rst_n & (~rsp_valid | rsp_ready); this is combinational from rsp_ready.
- Memory contents are not initialised and not reset.

## Timing
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0 (gated to 0 whenever rsp_valid=0), req_ready=0 while rst_n low, state EMPTY.
- Latency: request accepted at edge N gives rsp_valid high in cycle N+1.
- Throughput: 1 request/cycle while rsp_ready is held high.
- Read-after-write: a load accepted at edge N+1 or later sees a store accepted at edge N.
- Reset asserted mid-operation: the pending response is discarded immediately. Stores already committed on earlier edges remain. No accept occurs on any edge while rst_n is low.
- Address wrap: none; req_addr covers exactly the memory.

## Configuration
- MEM_SIGNED_LOAD_EN defined: a load with req_signed=1 replicates the MSB of the extracted 2^size bytes up to DATA_W. Loads of the full word are unaffected.
- Undefined: req_signed is ignored and all loads are zero-extended.

## Test plan
- DATA_W=32: store word 0x11223344 @0x0010 → err 0. Then load byte @0x0011 → 0x00000022; load half @0x0012 → 0x00003344.
- Store byte 0xAB @0x0013, then load word @0x0010 → 0x112233AB; lanes 0–2 unchanged.
- Load half @0x0011 and store word @0x0012 → rsp_err=1, rsp_rdata=0; a following load word @0x0010 still returns 0x112233AB. DATA_W=32 with size 3 → err.
- Store byte 0x80 @0x0020, then signed byte load → 0xFFFFFF80 with MEM_SIGNED_LOAD_EN, 0x00000080 without.
- Hold rsp_ready=0 for 3 cycles with req_valid high → req_ready=0, response held stable. Release rsp_ready → one accept per cycle, responses in order, no loss or duplication.
- Assert rst_n low while FULL → rsp_valid=0 and req_ready=0 immediately. After release, data from stores committed before reset reads back correctly.
